// File: rtl/tile_dispatch_scheduler.sv
// Frame tile dispatch scheduler: walks a frame in row-major tiles and hands each
// tile descriptor to a free compute core with round-robin selection, tracking
// per-core outstanding work until the frame drains.
// Optional build macro: TILE_DISPATCH_PERF_EN adds stall/backpressure counters.
module tile_dispatch_scheduler #(
   parameter int unsigned NUM_CORES = 2,
   parameter int unsigned WIDTH     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_frame_h,
   input  logic [WIDTH-1:0]     i_frame_w,
   input  logic [WIDTH-1:0]     i_tile_rows,
   input  logic [WIDTH-1:0]     i_tile_cols_max,
   output logic [NUM_CORES-1:0] o_core_tile_valid,
   input  logic [NUM_CORES-1:0] i_core_tile_ready,
   output logic [WIDTH-1:0]     o_tile_row0,
   output logic [WIDTH-1:0]     o_tile_col0,
   output logic [WIDTH-1:0]     o_tile_h,
   output logic [WIDTH-1:0]     o_tile_w,
   input  logic [NUM_CORES-1:0] i_core_tile_done,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [WIDTH-1:0]     o_tiles_issued
`ifdef TILE_DISPATCH_PERF_EN
   ,
   output logic [WIDTH-1:0]     o_stall_cycles,
   output logic [WIDTH-1:0]     o_bp_cycles
`endif
);

   localparam int unsigned PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e               r_state, w_state_next;
   logic [WIDTH-1:0]     r_frame_h, r_frame_w, r_tile_rows, r_tile_cols;
   logic [WIDTH:0]       r_cur_row, r_cur_col;
   logic                 r_more;
   logic [NUM_CORES-1:0] r_valid, r_outst;
   logic [PW-1:0]        r_rr_ptr;
   logic [WIDTH-1:0]     r_row0, r_col0, r_h, r_w, r_tiles_issued;
   logic                 r_done;

   logic                 w_idle, w_start_ok, w_geo_zero;
   logic [NUM_CORES-1:0] w_accept, w_elig, w_tgt_oh, w_outst_next;
   logic                 w_acc_any, w_tgt_found, w_load;
   int unsigned          w_acc_idx, w_ptr, w_tgt_idx;
   logic [WIDTH-1:0]     w_fh, w_fw, w_tr, w_tc, w_rem_h, w_rem_w, w_h, w_w;
   logic [WIDTH:0]       w_cur_row, w_cur_col, w_sum_col, w_nxt_row, w_nxt_col;
   logic                 w_nxt_more;

   // Accept decode, eligibility and round-robin target search
   always_comb begin : p_dispatch
      int unsigned k;
      w_idle     = (r_state == StIdle);
      w_start_ok = w_idle && i_start;
      w_geo_zero = (i_frame_h == '0) || (i_frame_w == '0) ||
                   (i_tile_rows == '0) || (i_tile_cols_max == '0);
      w_accept   = r_valid & i_core_tile_ready;
      w_acc_any  = |w_accept;
      w_acc_idx  = 0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (w_accept[i]) w_acc_idx = i;
      end
      // The first tile of a frame always starts the search at core 0
      if (w_idle)         w_ptr = 0;
      else if (w_acc_any) w_ptr = (w_acc_idx + 1 >= NUM_CORES) ? 0 : w_acc_idx + 1;
      else                w_ptr = 32'(r_rr_ptr);
      w_elig      = ~r_outst & ~w_accept;
      w_tgt_found = 1'b0;
      w_tgt_idx   = 0;
      k           = 0;
      for (int i = 0; i < NUM_CORES; i++) begin
         k = w_ptr + i;
         if (k >= NUM_CORES) k = k - NUM_CORES;
         if (!w_tgt_found && w_elig[k]) begin
            w_tgt_found = 1'b1;
            w_tgt_idx   = k;
         end
      end
      w_tgt_oh            = '0;
      w_tgt_oh[w_tgt_idx] = 1'b1;
      w_load = (w_start_ok && !w_geo_zero) ||
               ((r_state == StIssue) && r_more && ((r_valid == '0) || w_acc_any) && w_tgt_found);
      // A done only clears a bit that is already set; accepts set fresh bits
      w_outst_next = (r_outst & ~i_core_tile_done) | w_accept;
   end

   // Cursor arithmetic and tile clipping; in IDLE the live inputs stand in for the latches
   always_comb begin
      w_fh      = w_idle ? i_frame_h       : r_frame_h;
      w_fw      = w_idle ? i_frame_w       : r_frame_w;
      w_tr      = w_idle ? i_tile_rows     : r_tile_rows;
      w_tc      = w_idle ? i_tile_cols_max : r_tile_cols;
      w_cur_row = w_idle ? '0 : r_cur_row;
      w_cur_col = w_idle ? '0 : r_cur_col;
      // Cursor is always inside the frame when loaded, so the remainders fit WIDTH
      w_rem_h   = w_fh - w_cur_row[WIDTH-1:0];
      w_rem_w   = w_fw - w_cur_col[WIDTH-1:0];
      w_h       = (w_tr < w_rem_h) ? w_tr : w_rem_h;
      w_w       = (w_tc < w_rem_w) ? w_tc : w_rem_w;
      w_sum_col = w_cur_col + {1'b0, w_tc};
      if (w_sum_col >= {1'b0, w_fw}) begin
         w_nxt_col = '0;
         w_nxt_row = w_cur_row + {1'b0, w_tr};
      end else begin
         w_nxt_col = w_sum_col;
         w_nxt_row = w_cur_row;
      end
      w_nxt_more = (w_nxt_row < {1'b0, w_fh});
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_next = w_geo_zero ? StDone : StIssue;
         StIssue: if (w_acc_any && !r_more) w_state_next = StDrain;
         StDrain: if ((r_outst & ~i_core_tile_done) == '0) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // State register, geometry latches, descriptor and bookkeeping registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= StIdle;
         r_frame_h      <= '0;
         r_frame_w      <= '0;
         r_tile_rows    <= '0;
         r_tile_cols    <= '0;
         r_cur_row      <= '0;
         r_cur_col      <= '0;
         r_more         <= 1'b0;
         r_valid        <= '0;
         r_outst        <= '0;
         r_rr_ptr       <= '0;
         r_row0         <= '0;
         r_col0         <= '0;
         r_h            <= '0;
         r_w            <= '0;
         r_tiles_issued <= '0;
         r_done         <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= (r_state == StDone);
         r_outst <= w_outst_next;
         if (w_start_ok) begin
            r_frame_h      <= i_frame_h;
            r_frame_w      <= i_frame_w;
            r_tile_rows    <= i_tile_rows;
            r_tile_cols    <= i_tile_cols_max;
            r_tiles_issued <= '0;
            r_rr_ptr       <= '0;
            r_cur_row      <= '0;
            r_cur_col      <= '0;
            r_more         <= 1'b0;
         end
         if (w_load) begin
            r_valid   <= w_tgt_oh;
            r_row0    <= w_cur_row[WIDTH-1:0];
            r_col0    <= w_cur_col[WIDTH-1:0];
            r_h       <= w_h;
            r_w       <= w_w;
            r_cur_row <= w_nxt_row;
            r_cur_col <= w_nxt_col;
            r_more    <= w_nxt_more;
         end else if (w_acc_any) begin
            r_valid <= '0;
         end
         if (w_acc_any) begin
            r_tiles_issued <= r_tiles_issued + 1'b1;
            r_rr_ptr       <= PW'(w_ptr);
         end
      end
   end

`ifdef TILE_DISPATCH_PERF_EN
   logic [WIDTH-1:0] r_stall_cycles, r_bp_cycles;
   logic             w_stall, w_bp;

   // Stall: a tile is waiting to be loaded but every core is busy or just accepted
   always_comb begin
      w_stall = (r_state == StIssue) && r_more && ((r_valid == '0) || w_acc_any) && !w_tgt_found;
      w_bp    = (r_valid != '0) && !w_acc_any;
   end

   // Saturating performance counters, cleared per frame
   always_ff @(posedge i_clk) begin
      if (i_rst || w_start_ok) begin
         r_stall_cycles <= '0;
         r_bp_cycles    <= '0;
      end else begin
         if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
         if (w_bp && (r_bp_cycles != '1))       r_bp_cycles    <= r_bp_cycles + 1'b1;
      end
   end

   assign o_stall_cycles = r_stall_cycles;
   assign o_bp_cycles    = r_bp_cycles;
`endif

   assign o_core_tile_valid = r_valid;
   assign o_tile_row0       = r_row0;
   assign o_tile_col0       = r_col0;
   assign o_tile_h          = r_h;
   assign o_tile_w          = r_w;
   assign o_busy            = (r_state == StIssue) || (r_state == StDrain);
   assign o_done            = r_done;
   assign o_tiles_issued    = r_tiles_issued;

endmodule
